// File: rtl/button_pkg.sv
// Shared definitions for the button press generator: code constants,
// FSM state type and the press-code classifier.
package button_pkg;

  localparam logic [3:0] BTN_NONE = 4'd15;
  localparam int         NUM_BTNS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } btn_gen_state_t;

  // Codes 0..7 each select one physical button.
  function automatic logic is_press_code(input logic [3:0] code);
    return code < 4'(NUM_BTNS);
  endfunction

endpackage

// File: rtl/button_press_gen_timer.sv
// Loadable down-counter used to time press and gap intervals.
// A load wins over counting; counting stops at zero so the value never wraps.
module btn_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load on state entry, otherwise count down while enabled and non-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/button_press_gen.sv
// Button press generator: replays button codes as an active-low 8-bit
// button vector (timed press followed by a release gap).
// Optional macro BUTTON_PRESS_GEN_QUEUE_EN adds a one-entry holding register
// so the next code can be accepted while the current one is still playing.
module button_press_gen
  import button_pkg::*;
#(
  parameter int PRESS_CYCLES = 1000,
  parameter int GAP_CYCLES   = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_button,
  output logic [7:0] btn,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int MAX_CYCLES = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  btn_gen_state_t   state;
  btn_gen_state_t   launch_state;
  logic             accept;
  logic             launch;
  logic [3:0]       launch_code;
  logic             timer_zero;
  logic             timer_load;
  logic             timer_en;
  logic [CNT_W-1:0] timer_val;
  logic             press_end;
  logic             gap_end;

  assign accept    = in_valid && in_ready;
  assign press_end = (state == PRESS) && timer_zero;
  assign gap_end   = (state == GAP) && timer_zero;

`ifdef BUTTON_PRESS_GEN_QUEUE_EN
  logic       hold_full;
  logic [3:0] hold_code;
  logic       hold_take;

  // A code arriving while a press/gap is still running is parked here.
  // At the final gap cycle an incoming code is launched directly instead.
  assign hold_take = accept && (state != IDLE) && !gap_end;
  assign in_ready  = !hold_full;

  // Holding register occupancy: set on park, cleared when the gap ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
    end else if (hold_take) begin
      hold_full <= 1'b1;
    end else if (gap_end) begin
      hold_full <= 1'b0;
    end
  end

  // Held code payload; only meaningful while hold_full is set.
  always_ff @(posedge clk) begin
    if (hold_take) begin
      hold_code <= in_button;
    end
  end
`else
  assign in_ready = (state == IDLE);
`endif

  // Decide whether a new code starts this edge and which one.
  always_comb begin
    launch      = 1'b0;
    launch_code = in_button;
    case (state)
      IDLE: launch = accept;
`ifdef BUTTON_PRESS_GEN_QUEUE_EN
      GAP: begin
        if (timer_zero) begin
          if (hold_full) begin
            launch      = 1'b1;
            launch_code = hold_code;
          end else begin
            launch = accept;
          end
        end
      end
`endif
      default: launch = 1'b0;
    endcase
  end

  // Classify the launched code into the state it enters.
  always_comb begin
    if (is_press_code(launch_code)) begin
      launch_state = PRESS;
    end else if (launch_code == BTN_NONE) begin
      launch_state = GAP;
    end else begin
      launch_state = IDLE;
    end
  end

  // Timer load on press/gap entry; a press ending always enters a gap.
  always_comb begin
    timer_load = press_end || (launch && (launch_state != IDLE));
    if (press_end || (launch_state == GAP)) begin
      timer_val = CNT_W'(GAP_CYCLES - 1);
    end else begin
      timer_val = CNT_W'(PRESS_CYCLES - 1);
    end
    timer_en = (state != IDLE);
  end

  btn_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .en       (timer_en),
    .zero     (timer_zero)
  );

  // Main FSM with registered button vector and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      btn   <= 8'hFF;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (launch) begin
        state <= launch_state;
        busy  <= (launch_state != IDLE);
        btn   <= (launch_state == PRESS) ? ~(8'b1 << launch_code[2:0]) : 8'hFF;
        err   <= (launch_state == IDLE);
        done  <= (state == GAP);
      end else begin
        case (state)
          PRESS: begin
            if (timer_zero) begin
              btn   <= 8'hFF;
              state <= GAP;
            end
          end
          GAP: begin
            if (timer_zero) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_press_gen.sv
// Bench for button_press_gen with PRESS_CYCLES=4, GAP_CYCLES=2.
module tb_button_press_gen;

  localparam int PC = 4;
  localparam int GC = 2;
`ifdef BUTTON_PRESS_GEN_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_button = 4'd0;
  logic [7:0] btn;
  logic       busy, done, err;

  int compared = 0;
  int mismatched = 0;

  button_press_gen #(.PRESS_CYCLES(PC), .GAP_CYCLES(GC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_button(in_button), .btn(btn), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] code;
    logic [7:0] btn;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  typedef struct {
    logic [7:0] btn;
    logic       busy;
    logic       done;
    logic       err;
  } out_t;

  vec_t tbl[$];
  out_t mq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [3:0] c, input logic [7:0] b,
                              input logic bs, input logic d, input logic e);
    vec_t r;
    r.v = v; r.code = c; r.btn = b; r.busy = bs; r.done = d; r.err = e;
    return r;
  endfunction

  // Legal shapes: all released, or exactly one button low.
  function automatic logic shape_ok(input logic [7:0] b);
    logic [7:0] z;
    z = ~b;
    return (z == 8'h00) || ((z & (z - 8'd1)) == 8'h00);
  endfunction

  // Expected per-cycle timeline of one code, appended to the model queue.
  function automatic void push_code(input logic [3:0] c);
    out_t o;
    if (c < 4'd8) begin
      for (int i = 0; i < PC; i++) begin
        o.btn = 8'hFF ^ (8'd1 << c); o.busy = 1; o.done = 0; o.err = 0; mq.push_back(o);
      end
    end
    if (c < 4'd8 || c == 4'd15) begin
      for (int i = 0; i < GC; i++) begin
        o.btn = 8'hFF; o.busy = 1; o.done = 0; o.err = 0; mq.push_back(o);
      end
      o.btn = 8'hFF; o.busy = 0; o.done = 1; o.err = 0; mq.push_back(o);
    end else begin
      o.btn = 8'hFF; o.busy = 0; o.done = 0; o.err = 1; mq.push_back(o);
    end
  endfunction

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] seq[$];
    logic [7:0] exp_seq[$];
    int naccept;
    logic acc;
    logic held_v;
    logic [3:0] held_c;
    out_t ex;

    // ---- reset state ----
    do_reset();
    check("reset_btn", btn, 8'hFF);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_ready", in_ready, 1);

    // ---- table: code 3, code 15, code 9 ----
    tbl.push_back(mk(1, 4'd3, 8'hF7, 1, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 4'd3, 8'hF7, 1, 0, 0));
    tbl.push_back(mk(0, 4'd0, 8'hFF, 1, 0, 0));
    tbl.push_back(mk(0, 4'd0, 8'hFF, 1, 0, 0));
    tbl.push_back(mk(0, 4'd0, 8'hFF, 0, 1, 0));
    tbl.push_back(mk(0, 4'd0, 8'hFF, 0, 0, 0));
    tbl.push_back(mk(1, 4'd15, 8'hFF, 1, 0, 0));
    tbl.push_back(mk(0, 4'd0, 8'hFF, 1, 0, 0));
    tbl.push_back(mk(0, 4'd0, 8'hFF, 0, 1, 0));
    tbl.push_back(mk(1, 4'd9, 8'hFF, 0, 0, 1));
    tbl.push_back(mk(0, 4'd0, 8'hFF, 0, 0, 0));
    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].v;
      in_button = tbl[i].code;
      @(posedge clk); #1;
      check($sformatf("tbl%0d_btn", i), btn, tbl[i].btn);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      check($sformatf("tbl%0d_done", i), done, tbl[i].done);
      check($sformatf("tbl%0d_err", i), err, tbl[i].err);
      check($sformatf("tbl%0d_ready", i), in_ready, QEN ? 1'b1 : !tbl[i].busy);
    end
    in_valid = 1'b0;

    // ---- async reset in the middle of a press ----
    in_valid = 1'b1; in_button = 4'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst_press1", btn, 8'hFE);
    @(posedge clk); #1;
    check("rst_press2", btn, 8'hFE);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_btn", btn, 8'hFF);
    check("rst_async_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_rel_ready", in_ready, 1);
    check("rst_rel_btn", btn, 8'hFF);
    check("rst_rel_busy", busy, 0);

    // ---- back-to-back codes 7 then 1 with in_valid held ----
    do_reset();
    @(posedge clk); #1;
    naccept = 0;
    in_valid = 1'b1; in_button = 4'd7;
    for (int cyc = 0; cyc < 14; cyc++) begin
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        naccept++;
        if (naccept == 1) in_button = 4'd1;
        else in_valid = 1'b0;
      end
      seq.push_back(btn);
      if (QEN && cyc >= 1 && cyc <= 5) check($sformatf("b2b_ready_held%0d", cyc), in_ready, 0);
    end
    in_valid = 1'b0;
    for (int i = 0; i < PC; i++) exp_seq.push_back(8'h7F);
    for (int i = 0; i < GC; i++) exp_seq.push_back(8'hFF);
    if (!QEN) exp_seq.push_back(8'hFF);
    for (int i = 0; i < PC; i++) exp_seq.push_back(8'hFD);
    exp_seq.push_back(8'hFF);
    for (int i = 0; i < exp_seq.size(); i++)
      check($sformatf("b2b_btn%0d", i), seq[i], exp_seq[i]);
    check("b2b_accepts", naccept, 2);

    // ---- random stream against the timeline model ----
    do_reset();
    @(posedge clk); #1;
    mq.delete();
    held_v = 1'b0;
    held_c = 4'd0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic m_ready;
      int r;
      in_valid = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 11);
      in_button = (r < 8) ? 4'(r) : (r < 10) ? 4'd15 : 4'(8 + $urandom_range(0, 6));
      m_ready = QEN ? !held_v : (mq.size() == 0);
      check("rnd_ready", in_ready, m_ready);
      acc = in_valid && m_ready;
      @(posedge clk);
      begin
        logic merge_done;
        merge_done = 1'b0;
        if (mq.size() == 0) begin
          if (acc) push_code(in_button);
        end else if (QEN && mq.size() == 1 && (held_v || acc)) begin
          void'(mq.pop_front());
          push_code(held_v ? held_c : in_button);
          held_v = 1'b0;
          merge_done = 1'b1;
        end else if (QEN && acc) begin
          held_v = 1'b1;
          held_c = in_button;
        end
        if (mq.size() != 0) ex = mq.pop_front();
        else begin ex.btn = 8'hFF; ex.busy = 0; ex.done = 0; ex.err = 0; end
        if (merge_done) ex.done = 1'b1;
      end
      #1;
      check("rnd_btn", btn, ex.btn);
      check("rnd_busy", busy, ex.busy);
      check("rnd_done", done, ex.done);
      check("rnd_err", err, ex.err);
      check("rnd_shape", shape_ok(btn), 1);
    end
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
